// File: rtl/ball_motion.sv
// Ball kinematics engine for the brick-breaker datapath.
// Steps a fixed-point ball position once per frame strobe. The ball reflects off the
// left, right and top walls and flips direction on brick hits. A paddle hit recomputes
// the X/Y velocity split with a bit-serial integer square root.
module ball_motion #(
    parameter int unsigned INT_W       = 10,
    parameter int unsigned FRAC_W      = 10,
    parameter int          X_MIN       = 0,
    parameter int          X_MAX       = 640,
    parameter int          Y_MIN       = 0,
    parameter int          Y_MAX       = 480,
    parameter int          BALL_SIZE   = 4,
    parameter int unsigned PLAT_W_LOG2 = 6,
    parameter int          START_X     = 318,
    parameter int          START_Y     = 400
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             launch,
    input  logic [INT_W-1:0] plat_x,
    input  logic             plat_col,
    input  logic             brick_col_x,
    input  logic             brick_col_y,
    output logic [INT_W-1:0] x,
    output logic [INT_W-1:0] y,
    output logic             x_du,
    output logic             y_du,
    output logic             busy,
    output logic             lost
);

    localparam int unsigned P_W       = INT_W + FRAC_W;
    localparam int unsigned C_W       = INT_W + 1;
    localparam int unsigned RT_W      = FRAC_W + 1;
    localparam int unsigned SQ_W      = 2 * RT_W;
    localparam int unsigned BIT_W     = $clog2(RT_W);
    localparam int unsigned HALF_PLAT = 1 << (PLAT_W_LOG2 - 1);

    localparam logic [P_W-1:0]   POS_X0  = P_W'(START_X) << FRAC_W;
    localparam logic [P_W-1:0]   POS_Y0  = P_W'(START_Y) << FRAC_W;
    localparam logic [P_W-1:0]   V_ONE   = P_W'(1) << FRAC_W;
    localparam logic [P_W-1:0]   X_RIGHT = P_W'(X_MAX - BALL_SIZE) << FRAC_W;
    localparam logic [P_W-1:0]   X_LEFT  = P_W'(X_MIN) << FRAC_W;
    localparam logic [P_W-1:0]   Y_TOP   = P_W'(Y_MIN) << FRAC_W;
    localparam logic [SQ_W-1:0]  ONE_SQ  = SQ_W'(1) << (2 * FRAC_W);
    localparam logic [C_W-1:0]   HALF_C  = C_W'(HALF_PLAT);
    localparam logic [C_W-1:0]   BHALF_C = C_W'(BALL_SIZE / 2);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(FRAC_W);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_SQRT,
        S_LOST
    } state_t;

    state_t            r_state;
    logic [P_W-1:0]    r_pos_x;
    logic [P_W-1:0]    r_pos_y;
    logic [P_W-1:0]    r_vx;
    logic [P_W-1:0]    r_vy;
    logic              r_x_du;
    logic              r_y_du;
    logic              r_busy;
    logic              r_lost;
    logic [RT_W-1:0]   r_root;
    logic [SQ_W-1:0]   r_rem;
    logic [BIT_W-1:0]  r_bit;

    logic [P_W-1:0]    w_step_x;
    logic [P_W-1:0]    w_step_y;
    logic [INT_W-1:0]  w_step_x_int;
    logic [INT_W-1:0]  w_step_y_int;
    logic              w_hit_right;
    logic              w_hit_left;
    logic              w_hit_top;
    logic              w_hit_bottom;
    logic [P_W-1:0]    w_pos_x_nxt;
    logic [P_W-1:0]    w_pos_y_nxt;
    logic              w_x_du_nxt;
    logic              w_y_du_nxt;
    logic              w_accept;

    logic [C_W-1:0]    w_c;
    logic [C_W-1:0]    w_p;
    logic              w_c_ge_p;
    logic [C_W-1:0]    w_diff;
    logic [C_W-1:0]    w_d;
    logic [P_W-1:0]    w_vx_new;
    logic [SQ_W-1:0]   w_vx_sq;
    logic [SQ_W-1:0]   w_rem_new;

    logic [RT_W-1:0]   w_trial;
    logic [SQ_W-1:0]   w_trial_sq;
    logic [RT_W-1:0]   w_root_nxt;

    // Candidate step per axis and wall detection on the stepped integer part
    always_comb begin
        w_step_x     = r_x_du ? (r_pos_x + r_vx) : (r_pos_x - r_vx);
        w_step_y     = r_y_du ? (r_pos_y + r_vy) : (r_pos_y - r_vy);
        w_step_x_int = w_step_x[P_W-1:FRAC_W];
        w_step_y_int = w_step_y[P_W-1:FRAC_W];
        w_hit_right  = r_x_du && ((int'(w_step_x_int) + BALL_SIZE) > X_MAX);
        w_hit_left   = !r_x_du && ((r_pos_x < r_vx) || (int'(w_step_x_int) < X_MIN));
        w_hit_top    = !r_y_du && ((r_pos_y < r_vy) || (int'(w_step_y_int) < Y_MIN));
        w_hit_bottom = enable && r_y_du && ((int'(w_step_y_int) + BALL_SIZE) >= Y_MAX);
    end

    // Paddle hit geometry: offset of ball centre from paddle centre sets the X speed
    always_comb begin
        w_accept  = (r_state == S_RUN) && r_y_du && plat_col;
        w_c       = C_W'(r_pos_x[P_W-1:FRAC_W]) + BHALF_C;
        w_p       = C_W'(plat_x) + HALF_C;
        w_c_ge_p  = (w_c >= w_p);
        w_diff    = w_c_ge_p ? (w_c - w_p) : (w_p - w_c);
        w_d       = (w_diff > HALF_C) ? HALF_C : w_diff;
        w_vx_new  = (P_W'(w_d) << FRAC_W) >> PLAT_W_LOG2;
        w_vx_sq   = SQ_W'(w_vx_new) * SQ_W'(w_vx_new);
        w_rem_new = ONE_SQ - w_vx_sq;
    end

    // One restoring square-root bit per cycle, MSB first
    always_comb begin
        w_trial    = r_root | (RT_W'(1) << r_bit);
        w_trial_sq = SQ_W'(w_trial) * SQ_W'(w_trial);
        w_root_nxt = (w_trial_sq <= r_rem) ? w_trial : r_root;
    end

    // Next position/direction; walls override brick toggles, paddle overrides both
    always_comb begin
        w_pos_x_nxt = r_pos_x;
        w_pos_y_nxt = r_pos_y;
        w_x_du_nxt  = r_x_du ^ brick_col_x;
        w_y_du_nxt  = r_y_du ^ brick_col_y;
        if (enable) begin
            if (w_hit_right) begin
                w_pos_x_nxt = X_RIGHT;
                w_x_du_nxt  = 1'b0;
            end else if (w_hit_left) begin
                w_pos_x_nxt = X_LEFT;
                w_x_du_nxt  = 1'b1;
            end else begin
                w_pos_x_nxt = w_step_x;
            end
            if (w_hit_top) begin
                w_pos_y_nxt = Y_TOP;
                w_y_du_nxt  = 1'b1;
            end else begin
                w_pos_y_nxt = w_step_y;
            end
        end
        if (w_accept) begin
            w_x_du_nxt = w_c_ge_p;
            w_y_du_nxt = 1'b0;
        end
    end

    // Motion FSM with all state and outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_HOLD;
            r_pos_x <= POS_X0;
            r_pos_y <= POS_Y0;
            r_vx    <= V_ONE;
            r_vy    <= V_ONE;
            r_x_du  <= 1'b1;
            r_y_du  <= 1'b0;
            r_busy  <= 1'b0;
            r_lost  <= 1'b0;
            r_root  <= '0;
            r_rem   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (launch) begin
                        r_state <= S_RUN;
                    end
                end
                S_LOST: begin
                    if (launch) begin
                        r_state <= S_HOLD;
                        r_pos_x <= POS_X0;
                        r_pos_y <= POS_Y0;
                        r_vx    <= V_ONE;
                        r_vy    <= V_ONE;
                        r_x_du  <= 1'b1;
                        r_y_du  <= 1'b0;
                        r_lost  <= 1'b0;
                    end
                end
                S_RUN, S_SQRT: begin
                    if (w_hit_bottom) begin
                        r_state <= S_LOST;
                        r_lost  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_pos_x <= w_pos_x_nxt;
                        r_pos_y <= w_pos_y_nxt;
                        r_x_du  <= w_x_du_nxt;
                        r_y_du  <= w_y_du_nxt;
                        if (r_state == S_SQRT) begin
                            r_root <= w_root_nxt;
                            if (r_bit == '0) begin
                                r_vy    <= P_W'(w_root_nxt);
                                r_busy  <= 1'b0;
                                r_state <= S_RUN;
                            end else begin
                                r_bit <= r_bit - BIT_W'(1);
                            end
                        end
                        if (w_accept) begin
                            r_vx    <= w_vx_new;
                            r_rem   <= w_rem_new;
                            r_root  <= '0;
                            r_bit   <= BIT_TOP;
                            r_busy  <= 1'b1;
                            r_state <= S_SQRT;
                        end
                    end
                end
                default: r_state <= S_HOLD;
            endcase
        end
    end

    assign x    = r_pos_x[P_W-1:FRAC_W];
    assign y    = r_pos_y[P_W-1:FRAC_W];
    assign x_du = r_x_du;
    assign y_du = r_y_du;
    assign busy = r_busy;
    assign lost = r_lost;

endmodule
